// File: rtl/m_mem_access.sv
// M-stage data-memory access controller: issues req/ack transactions for loads
// and stores, stalls the pipeline while outstanding, and extends load data.
module m_mem_access #(
  parameter int MAX_WAIT = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        m_load,
  input  logic        m_store,
  input  logic [1:0]  m_size,
  input  logic        m_signed,
  input  logic [31:0] m_addr,
  input  logic [31:0] m_wdata,
  output logic        m_stall,
  output logic [31:0] m_rdata,
  output logic        m_rdata_valid,
  output logic        m_addr_err,
  output logic        m_bus_err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t      state_q, state_d;
  logic        req_q, req_d, we_q, we_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d;
  logic [3:0]  be_q, be_d;
  logic        rdv_q, rdv_d, berr_q, berr_d;
  logic [7:0]  cnt_q, cnt_d;
  // Load shape is captured at issue so extension does not depend on E/M staying frozen.
  logic [1:0]  sz_q, sz_d, lane_q, lane_d;
  logic        sgn_q, sgn_d, ld_q, ld_d;

  logic        any_op, aligned, acc_ok;
  logic [3:0]  be_new;
  logic [31:0] wd_new, ld_ext;
  logic [7:0]  ld_b;
  logic [15:0] ld_h;

  always_comb begin
    any_op  = m_load | m_store;
    aligned = (m_size == 2'b00) ||
              (m_size == 2'b01 && !m_addr[0]) ||
              (m_size == 2'b10 && m_addr[1:0] == 2'b00);
    acc_ok  = (m_load ^ m_store) && (m_size != 2'b11) && aligned;
    case (m_size)
      2'b00:   begin be_new = 4'b0001 << m_addr[1:0]; wd_new = {4{m_wdata[7:0]}};  end
      2'b01:   begin be_new = 4'b0011 << m_addr[1:0]; wd_new = {2{m_wdata[15:0]}}; end
      default: begin be_new = 4'b1111;                wd_new = m_wdata;            end
    endcase
  end

  always_comb begin
    ld_b = mem_rdata[8*lane_q +: 8];
    ld_h = mem_rdata[16*lane_q[1] +: 16];
    case (sz_q)
      2'b00:   ld_ext = {{24{sgn_q & ld_b[7]}}, ld_b};
      2'b01:   ld_ext = {{16{sgn_q & ld_h[15]}}, ld_h};
      default: ld_ext = mem_rdata;
    endcase
  end

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    we_d    = we_q;
    addr_d  = addr_q;
    be_d    = be_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    cnt_d   = cnt_q;
    sz_d    = sz_q;
    lane_d  = lane_q;
    sgn_d   = sgn_q;
    ld_d    = ld_q;
    rdv_d   = 1'b0;
    berr_d  = 1'b0;
    case (state_q)
      IDLE: if (acc_ok) begin
        state_d = ACCESS;
        req_d   = 1'b1;
        we_d    = m_store;
        addr_d  = {m_addr[31:2], 2'b00};
        be_d    = be_new;
        wdata_d = wd_new;
        cnt_d   = '0;
        sz_d    = m_size;
        lane_d  = m_addr[1:0];
        sgn_d   = m_signed;
        ld_d    = m_load;
      end
      ACCESS: begin
        cnt_d = cnt_q + 8'd1;
        // An ack in the final watchdog cycle still wins over the abort.
        if (mem_ack) begin
          state_d = DONE;
          req_d   = 1'b0;
          rdata_d = ld_q ? ld_ext : '0;
          rdv_d   = 1'b1;
        end else if (cnt_q == 8'(MAX_WAIT - 1)) begin
          state_d = DONE;
          req_d   = 1'b0;
          rdata_d = '0;
          rdv_d   = 1'b1;
          berr_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      be_q    <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      rdv_q   <= 1'b0;
      berr_q  <= 1'b0;
      cnt_q   <= '0;
      sz_q    <= '0;
      lane_q  <= '0;
      sgn_q   <= 1'b0;
      ld_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      rdv_q   <= rdv_d;
      berr_q  <= berr_d;
      cnt_q   <= cnt_d;
      sz_q    <= sz_d;
      lane_q  <= lane_d;
      sgn_q   <= sgn_d;
      ld_q    <= ld_d;
    end
  end

  assign m_stall       = !reset && ((state_q == IDLE && acc_ok) || state_q == ACCESS);
  assign m_addr_err    = !reset && state_q == IDLE && any_op && !acc_ok;
  assign m_rdata       = rdata_q;
  assign m_rdata_valid = rdv_q;
  assign m_bus_err     = berr_q;
  assign mem_req       = req_q;
  assign mem_we        = we_q;
  assign mem_addr      = addr_q;
  assign mem_be        = be_q;
  assign mem_wdata     = wdata_q;

endmodule
